// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: Depth x Width registers.
// One synchronous write port and one registered read port; the read register clears on reset.
module sync_fifo_mem #(
  parameter int Depth = 8,
  parameter int Width = 16,
  localparam int AW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [Width-1:0] w_data,
  input  logic             r_en,
  input  logic [AW-1:0]    r_addr,
  output logic [Width-1:0] r_data
);

  logic [Width-1:0] mem [Depth];

  // Array contents survive reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
    end else if (r_en) begin
      r_data <= mem[r_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, registered full/empty flags and accept logic.
// Storage and the registered read data live in sync_fifo_mem.
module sync_fifo #(
  parameter int Depth = 8,
  parameter int Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_enb,
  input  logic             r_enb,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);
  localparam logic [AW-1:0] LAST = AW'(Depth - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          wr_acc;
  logic          rd_acc;

  // Acceptance uses the flags as registered before this edge; reset blocks both.
  assign wr_acc = reset && w_enb && !full;
  assign rd_acc = reset && r_enb && !empty;

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc) begin
      count_next = count + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      end
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

  sync_fifo_mem #(
    .Depth(Depth),
    .Width(Width)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .w_en  (wr_acc),
    .w_addr(wr_ptr),
    .w_data(din),
    .r_en  (rd_acc),
    .r_addr(rd_ptr),
    .r_data(dout)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_sync_fifo;

  localparam int Depth = 8;
  localparam int Width = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             w_enb = 1'b0;
  logic             r_enb = 1'b0;
  logic [Width-1:0] din = '0;
  logic [Width-1:0] dout;
  logic             full;
  logic             empty;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  logic [Width-1:0] q[$];
  logic [Width-1:0] m_dout = '0;

  sync_fifo #(.Depth(Depth), .Width(Width)) dut (
    .clk  (clk),
    .reset(reset),
    .w_enb(w_enb),
    .r_enb(r_enb),
    .din  (din),
    .dout (dout),
    .full (full),
    .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: a queue with capacity Depth; decisions use occupancy before the edge.
  always @(posedge clk) begin
    bit wa;
    bit ra;
    if (!reset) begin
      q.delete();
      m_dout = '0;
    end else begin
      wa = w_enb && (q.size() < Depth);
      ra = r_enb && (q.size() > 0);
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (dout !== m_dout) begin
        miscompares++;
        $display("FAIL model_dout t=%0t got=%h want=%h", $time, dout, m_dout);
      end
      vectors++;
      if (full !== (q.size() == Depth)) begin
        miscompares++;
        $display("FAIL model_full t=%0t got=%b want=%b", $time, full, q.size() == Depth);
      end
      vectors++;
      if (empty !== (q.size() == 0)) begin
        miscompares++;
        $display("FAIL model_empty t=%0t got=%b want=%b", $time, empty, q.size() == 0);
      end
    end
  end

  task automatic lit(input string name, input logic [Width-1:0] act, input logic [Width-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then return at the following falling edge.
  task automatic tick(input logic rst_n, input logic w, input logic r, input logic [Width-1:0] d);
    reset = rst_n;
    w_enb = w;
    r_enb = r;
    din   = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    tick(1'b0, 1'b1, 1'b1, 16'h1234);
    tick(1'b0, 1'b0, 1'b0, 16'h0000);
    chk_on = 1'b1;
    lit("reset_empty", 16'(empty), 16'h1);
    lit("reset_full", 16'(full), 16'h0);
    lit("reset_dout", dout, 16'h0000);

    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b1, 1'b0, 16'(i));
      if (i == 1) lit("fill_empty_low", 16'(empty), 16'h0);
      if (i == 7) lit("fill_not_full_7", 16'(full), 16'h0);
    end
    lit("fill_full", 16'(full), 16'h1);

    tick(1'b1, 1'b1, 1'b0, 16'hDEAD);
    lit("overflow_full", 16'(full), 16'h1);

    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 1'b0, 1'b1, 16'h0);
      lit("drain_dout", dout, 16'(i));
    end
    lit("drain_empty", 16'(empty), 16'h1);
    tick(1'b1, 1'b0, 1'b1, 16'h0);
    lit("underflow_dout", dout, 16'h0008);
    lit("underflow_empty", 16'(empty), 16'h1);

    tick(1'b1, 1'b1, 1'b1, 16'h00AA);
    lit("sim_empty_flag", 16'(empty), 16'h0);
    lit("sim_empty_dout", dout, 16'h0008);
    tick(1'b1, 1'b1, 1'b1, 16'h00BB);
    lit("sim_dout_aa", dout, 16'h00AA);
    tick(1'b1, 1'b1, 1'b1, 16'h00CC);
    lit("sim_dout_bb", dout, 16'h00BB);
    tick(1'b1, 1'b1, 1'b1, 16'h00DD);
    lit("sim_dout_cc", dout, 16'h00CC);
    lit("sim_count_empty", 16'(empty), 16'h0);
    lit("sim_count_full", 16'(full), 16'h0);

    tick(1'b1, 1'b0, 1'b1, 16'h0);
    lit("sim_dout_dd", dout, 16'h00DD);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'b0, 16'h0100 + 16'(i));
      tick(1'b1, 1'b0, 1'b1, 16'h0);
      lit("wrap_dout", dout, 16'h0100 + 16'(i));
    end

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 16'h0200 + 16'(i));
    tick(1'b0, 1'b1, 1'b1, 16'h0F0F);
    lit("midreset_empty", 16'(empty), 16'h1);
    lit("midreset_full", 16'(full), 16'h0);
    lit("midreset_dout", dout, 16'h0000);

    for (int n = 0; n < 3000; n++) begin
      logic rn;
      logic w;
      logic r;
      rn = ($urandom_range(0, 199) != 0);
      w  = ($urandom_range(0, 99) < ((n / 500) % 2 ? 70 : 40));
      r  = ($urandom_range(0, 99) < ((n / 500) % 2 ? 40 : 70));
      tick(rn, w, r, 16'($urandom));
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
